// File: rtl/vga_timing_src_if.sv
// vga_timing_src_if: pixel fetch handshake towards the DDR3 read FIFO plus
// the aligned video bus towards the gamma correction stage.
// master = timing source, slave = FIFO / gamma side.
interface vga_timing_src_if;
  logic        o_pix_req;
  logic        i_fifo_empty;
  logic [23:0] i_pix_data;
  logic        o_vga_vsync;
  logic        o_vga_hsync;
  logic        o_vga_de;
  logic [7:0]  o_vga_r;
  logic [7:0]  o_vga_g;
  logic [7:0]  o_vga_b;

  modport master (
    output o_pix_req,
    input  i_fifo_empty,
    input  i_pix_data,
    output o_vga_vsync,
    output o_vga_hsync,
    output o_vga_de,
    output o_vga_r,
    output o_vga_g,
    output o_vga_b
  );

  modport slave (
    input  o_pix_req,
    output i_fifo_empty,
    output i_pix_data,
    input  o_vga_vsync,
    input  o_vga_hsync,
    input  o_vga_de,
    input  o_vga_r,
    input  o_vga_g,
    input  o_vga_b
  );
endinterface

// File: rtl/vga_timing_src.sv
// vga_timing_src: programmable video timing generator and pixel fetch stage.
// h/v counters -> stage 0 decode (combinational, drives the FIFO read strobe)
// -> stage 1 registers (aligned with FIFO read data) -> stage 2 output regs.
// Optional macro VGA_TEST_PATTERN_EN adds i_pattern_sel, which replaces the
// FIFO stream with 8 vertical colour bars.
module vga_timing_src #(
  parameter int H_SYNC   = 40,
  parameter int H_BACK   = 220,
  parameter int H_ACTIVE = 1280,
  parameter int H_FRONT  = 110,
  parameter int V_SYNC   = 5,
  parameter int V_BACK   = 20,
  parameter int V_ACTIVE = 720,
  parameter int V_FRONT  = 5,
  parameter int SYNC_POL = 1
) (
  input  logic sclk,
  input  logic s_rst,
  input  logic i_en,
  input  logic i_clr_err,
`ifdef VGA_TEST_PATTERN_EN
  input  logic i_pattern_sel,
`endif
  output logic o_frame_start,
  output logic o_underflow,
  vga_timing_src_if.master vga
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  // Decode constants carry one spare bit so an active window ending exactly
  // at the line/frame total cannot wrap.
  localparam logic [HW:0] H_LAST     = (HW+1)'(H_TOTAL - 1);
  localparam logic [HW:0] H_SYNC_END = (HW+1)'(H_SYNC);
  localparam logic [HW:0] H_ACT_BEG  = (HW+1)'(H_SYNC + H_BACK);
  localparam logic [HW:0] H_ACT_END  = (HW+1)'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [VW:0] V_LAST     = (VW+1)'(V_TOTAL - 1);
  localparam logic [VW:0] V_SYNC_END = (VW+1)'(V_SYNC);
  localparam logic [VW:0] V_ACT_BEG  = (VW+1)'(V_SYNC + V_BACK);
  localparam logic [VW:0] V_ACT_END  = (VW+1)'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic        SYNC_ON    = (SYNC_POL != 0);

  // counters
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [HW:0]   h_ext;
  logic [VW:0]   v_ext;

  // stage 0
  logic       hs_pre, vs_pre, de_pre;
  logic       pix_req;
  logic       pat_sel;
  logic [2:0] bar_idx_pre;

  // stage 1
  logic       hs1_q, hs1_d;
  logic       vs1_q, vs1_d;
  logic       de1_q, de1_d;
  logic       u1_q, u1_d;
  logic       pat1_q, pat1_d;
  logic [2:0] bar1_q, bar1_d;
  logic       fs_q, fs_d;

  // stage 2
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        de2_q, de2_d;
  logic [23:0] rgb_q, rgb_d;
  logic        ufl_q, ufl_d;
  logic [23:0] bar_rgb;

  assign h_ext = {1'b0, h_cnt_q};
  assign v_ext = {1'b0, v_cnt_q};

  // Counters run only while enabled; disabling parks them at the frame origin.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!i_en) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_ext == H_LAST) begin
      h_cnt_d = '0;
      if (v_ext == V_LAST) begin
        v_cnt_d = '0;
      end else begin
        v_cnt_d = v_cnt_q + 1'b1;
      end
    end else begin
      h_cnt_d = h_cnt_q + 1'b1;
    end
  end

  assign hs_pre = (h_ext < H_SYNC_END);
  assign vs_pre = (v_ext < V_SYNC_END);
  assign de_pre = (h_ext >= H_ACT_BEG) && (h_ext < H_ACT_END) &&
                  (v_ext >= V_ACT_BEG) && (v_ext < V_ACT_END);

`ifdef VGA_TEST_PATTERN_EN
  logic [HW-1:0] bar_off;
  logic [HW-1:0] bar_div;
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? (H_ACTIVE / 8) : 1;

  assign pat_sel = i_pattern_sel;

  // Bar index from the offset into the active line; the last bar absorbs any remainder.
  always_comb begin
    bar_off     = h_cnt_q - H_ACT_BEG[HW-1:0];
    bar_div     = bar_off / HW'(BAR_W);
    bar_idx_pre = (bar_div > HW'(7)) ? 3'd7 : bar_div[2:0];
  end
`else
  assign pat_sel     = 1'b0;
  assign bar_idx_pre = 3'd0;
`endif

  // Read strobe is combinational so FIFO data lands exactly in stage 1.
  assign pix_req = de_pre & i_en & ~pat_sel;

  // Bar colours: r/g/b switch with index bits 1/2/0 (white..black order).
  always_comb begin
    bar_rgb = {{8{~bar1_q[1]}}, {8{~bar1_q[2]}}, {8{~bar1_q[0]}}};
  end

  // Next state for both pipeline stages and the sticky underflow flag.
  always_comb begin
    hs1_d  = hs_pre & i_en;
    vs1_d  = vs_pre & i_en;
    de1_d  = de_pre & i_en;
    u1_d   = pix_req & vga.i_fifo_empty;
    pat1_d = pat_sel;
    bar1_d = bar_idx_pre;
    fs_d   = i_en && (h_cnt_q == '0) && (v_cnt_q == '0);

    hsync_d = hs1_q ? SYNC_ON : ~SYNC_ON;
    vsync_d = vs1_q ? SYNC_ON : ~SYNC_ON;
    de2_d   = de1_q;
    rgb_d   = 24'h000000;
    if (de1_q) begin
      if (pat1_q) begin
        rgb_d = bar_rgb;
      end else if (!u1_q) begin
        rgb_d = vga.i_pix_data;
      end
    end

    // set wins over a simultaneous clear
    ufl_d = ufl_q;
    if (u1_q) begin
      ufl_d = 1'b1;
    end else if (i_clr_err) begin
      ufl_d = 1'b0;
    end
  end

  // All state registers with synchronous reset.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      de1_q   <= 1'b0;
      u1_q    <= 1'b0;
      pat1_q  <= 1'b0;
      bar1_q  <= 3'd0;
      fs_q    <= 1'b0;
      hsync_q <= ~SYNC_ON;
      vsync_q <= ~SYNC_ON;
      de2_q   <= 1'b0;
      rgb_q   <= 24'h000000;
      ufl_q   <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      hs1_q   <= hs1_d;
      vs1_q   <= vs1_d;
      de1_q   <= de1_d;
      u1_q    <= u1_d;
      pat1_q  <= pat1_d;
      bar1_q  <= bar1_d;
      fs_q    <= fs_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de2_q   <= de2_d;
      rgb_q   <= rgb_d;
      ufl_q   <= ufl_d;
    end
  end

  assign vga.o_pix_req   = pix_req;
  assign vga.o_vga_hsync = hsync_q;
  assign vga.o_vga_vsync = vsync_q;
  assign vga.o_vga_de    = de2_q;
  assign vga.o_vga_r     = rgb_q[23:16];
  assign vga.o_vga_g     = rgb_q[15:8];
  assign vga.o_vga_b     = rgb_q[7:0];
  assign o_frame_start   = fs_q;
  assign o_underflow     = ufl_q;

endmodule

// File: tb/tb_vga_timing_src.sv
// tb_vga_timing_src: randomized scoreboard bench for vga_timing_src.
// Two instances share all stimulus: one active-high sync, one active-low.
// The reference model derives every output from the frame position with
// plain arithmetic and the input history of the last two cycles.
module tb_vga_timing_src;
  localparam int HS = 2, HB = 2, HA = 8, HF = 2;
  localparam int VS = 1, VB = 1, VA = 4, VF = 1;
  localparam int HT = HS + HB + HA + HF;   // 14
  localparam int VT = VS + VB + VA + VF;   // 7
  localparam int FT = HT * VT;             // 98
`ifdef VGA_TEST_PATTERN_EN
  localparam bit PAT_OK = 1'b1;
`else
  localparam bit PAT_OK = 1'b0;
`endif

  typedef struct {
    bit          req;
    bit          fs;
    bit          ufl;
    bit          hs;
    bit          vs;
    bit          de;
    logic [23:0] rgb;
  } exp_t;

  logic        clk;
  logic        rst, en, clr, fifo_empty, pat;
  logic [23:0] pix_data;
  logic        fs_p, fs_n, ufl_p, ufl_n;

  vga_timing_src_if bus_p ();
  vga_timing_src_if bus_n ();

  assign bus_p.i_fifo_empty = fifo_empty;
  assign bus_p.i_pix_data   = pix_data;
  assign bus_n.i_fifo_empty = fifo_empty;
  assign bus_n.i_pix_data   = pix_data;

  vga_timing_src #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF), .SYNC_POL(1)
  ) dut_p (
    .sclk(clk), .s_rst(rst), .i_en(en), .i_clr_err(clr),
`ifdef VGA_TEST_PATTERN_EN
    .i_pattern_sel(pat),
`endif
    .o_frame_start(fs_p), .o_underflow(ufl_p), .vga(bus_p)
  );

  vga_timing_src #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF), .SYNC_POL(0)
  ) dut_n (
    .sclk(clk), .s_rst(rst), .i_en(en), .i_clr_err(clr),
`ifdef VGA_TEST_PATTERN_EN
    .i_pattern_sel(pat),
`endif
    .o_frame_start(fs_n), .o_underflow(ufl_n), .vga(bus_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_print = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  bit   frame_chk = 0;

  // per-cycle input history (ring of 4), indexed by cycle number
  bit          r_rst[4];
  bit          r_en[4];
  bit          r_clr[4];
  bit          r_emp[4];
  bit          r_pat[4];
  int          r_pos[4];
  logic [23:0] r_dat[4];
  int          pos_m = 0;
  bit          ufl_m = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      if (n_print < 40) begin
        n_print++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, expv);
      end
    end
  endtask

  function automatic bit is_active(input int p);
    int h, v;
    h = p % HT;
    v = p / HT;
    return (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
  endfunction

  function automatic logic [23:0] bar_colour(input int p);
    logic [23:0] tbl [8];
    int idx;
    tbl = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    idx = ((p % HT) - HS - HB) / (HA / 8);
    if (idx > 7) idx = 7;
    return tbl[idx];
  endfunction

  // Drive one cycle of inputs, push the expectation for this cycle, advance.
  task automatic step(input bit r, input bit e, input bit c, input bit emp, input bit p);
    int   i0, i1, i2;
    bit   ok2, uf2;
    exp_t x;
    rst        = r;
    en         = e;
    clr        = c;
    fifo_empty = emp;
    pat        = p & PAT_OK;
    pix_data   = 24'($urandom);
    i0 = cyc & 3;
    i1 = (cyc + 3) & 3;
    i2 = (cyc + 2) & 3;
    r_rst[i0] = r;
    r_en[i0]  = e;
    r_clr[i0] = c;
    r_emp[i0] = emp;
    r_pat[i0] = pat;
    r_pos[i0] = pos_m;
    r_dat[i0] = pix_data;

    x.req = e && is_active(pos_m) && !pat;
    if (r_rst[i1]) begin
      x.fs = 0; x.ufl = 0; x.hs = 0; x.vs = 0; x.de = 0; x.rgb = 24'h0;
    end else begin
      x.fs  = r_en[i1] && (r_pos[i1] == 0);
      ok2   = !r_rst[i2] && r_en[i2];
      x.hs  = ok2 && ((r_pos[i2] % HT) < HS);
      x.vs  = ok2 && ((r_pos[i2] / HT) < VS);
      x.de  = ok2 && is_active(r_pos[i2]);
      uf2   = x.de && !r_pat[i2] && r_emp[i2];
      if (!x.de)          x.rgb = 24'h0;
      else if (r_pat[i2]) x.rgb = bar_colour(r_pos[i2]);
      else if (uf2)       x.rgb = 24'h0;
      else                x.rgb = r_dat[i1];
      x.ufl = uf2 || (ufl_m && !r_clr[i1]);
    end
    ufl_m = x.ufl;
    if (cyc > 0) exp_q.push_back(x);

    @(posedge clk);
    #1;
    if (r || !e) pos_m = 0;
    else         pos_m = (pos_m + 1) % FT;
    cyc++;
  endtask

  // Run enabled until the model reaches a target position (-1: any active pixel).
  task automatic seek(input int target);
    int n;
    n = 0;
    while (n < 2 * FT && !((target < 0) ? is_active(pos_m) : (pos_m == target))) begin
      step(0, 1, 0, 0, 0);
      n++;
    end
    chk("seek_bound", 32'(n < 2 * FT), 32'd1);
  endtask

  // Monitor: pop one expectation per cycle and compare both instances.
  exp_t e_m;
  int   since_fs = 0;
  int   req_cnt = 0;
  bit   have_prev = 0;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e_m = exp_q.pop_front();
      chk("pix_req",       32'(bus_p.o_pix_req),   32'(e_m.req));
      chk("pix_req_n",     32'(bus_n.o_pix_req),   32'(e_m.req));
      chk("frame_start",   32'(fs_p),              32'(e_m.fs));
      chk("frame_start_n", 32'(fs_n),              32'(e_m.fs));
      chk("underflow",     32'(ufl_p),             32'(e_m.ufl));
      chk("underflow_n",   32'(ufl_n),             32'(e_m.ufl));
      chk("de",            32'(bus_p.o_vga_de),    32'(e_m.de));
      chk("de_n",          32'(bus_n.o_vga_de),    32'(e_m.de));
      chk("hsync_pos",     32'(bus_p.o_vga_hsync), 32'(e_m.hs));
      chk("hsync_neg",     32'(bus_n.o_vga_hsync), 32'(!e_m.hs));
      chk("vsync_pos",     32'(bus_p.o_vga_vsync), 32'(e_m.vs));
      chk("vsync_neg",     32'(bus_n.o_vga_vsync), 32'(!e_m.vs));
      chk("rgb",   32'({bus_p.o_vga_r, bus_p.o_vga_g, bus_p.o_vga_b}), 32'(e_m.rgb));
      chk("rgb_n", 32'({bus_n.o_vga_r, bus_n.o_vga_g, bus_n.o_vga_b}), 32'(e_m.rgb));
    end
    // frame cadence and request count during the clean streaming phase
    if (!frame_chk) begin
      have_prev = 0;
    end else if (fs_p === 1'b1) begin
      if (have_prev) begin
        chk("frame_period", 32'(since_fs), 32'(FT));
        chk("frame_reqs",   32'(req_cnt),  32'(HA * VA));
      end
      have_prev = 1;
      since_fs  = 0;
      req_cnt   = 0;
    end
    since_fs++;
    if (bus_p.o_pix_req === 1'b1) req_cnt++;
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      r_rst[i] = 1; r_en[i] = 0; r_clr[i] = 0; r_emp[i] = 0;
      r_pat[i] = 0; r_pos[i] = 0; r_dat[i] = 24'h0;
    end
    // reset
    repeat (3) step(1, 0, 0, 0, 0);
    // clean streaming, FIFO never empty
    frame_chk = 1;
    repeat (3 * FT + 5) step(0, 1, 0, 0, 0);
    frame_chk = 0;
    // single underflow in the second active line, then a plain clear
    seek((VS + VB + 1) * HT + HS + HB + 3);
    step(0, 1, 0, 1, 0);
    repeat (3) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    repeat (3) step(0, 1, 0, 0, 0);
    // underflow set coinciding with clear: flag must stay set
    seek(-1);
    step(0, 1, 0, 1, 0);
    step(0, 1, 1, 0, 0);
    repeat (4) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    repeat (2) step(0, 1, 0, 0, 0);
    // drop enable mid-active line, then restart a frame
    seek(-1);
    repeat (5) step(0, 0, 0, 0, 0);
    repeat (FT + 10) step(0, 1, 0, 0, 0);
    // reset during active video
    seek(-1);
    step(1, 1, 0, 0, 0);
    repeat (FT + 4) step(0, 1, 0, 0, 0);
    // colour bars (only effective with the pattern option compiled in)
    repeat (FT + 5) step(0, 1, 0, 0, 1);
    // randomized mix of everything
    for (int i = 0; i < 2500; i++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 59) != 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) == 0);
    end
    repeat (3) step(0, 0, 0, 0, 0);
    chk("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_timing_src.md
Name: vga_timing_src

Overview:
- Video timing generator and pixel fetch stage directly upstream of the gamma correction stage.
- Produces vsync/hsync/de from programmable horizontal and vertical counters.
- Pulls RGB888 pixels from the DDR3 read-side FIFO during active video and presents aligned vsync/hsync/de/r/g/b to the gamma input.
- Flags FIFO underflow and emits a frame-start pulse so the DDR3 read controller can re-arm per frame.

Parameters:
- H_SYNC, 40, hsync width in clocks
- H_BACK, 220, horizontal back porch
- H_ACTIVE, 1280, active pixels per line
- H_FRONT, 110, horizontal front porch
- V_SYNC, 5, vsync width in lines
- V_BACK, 20, vertical back porch
- V_ACTIVE, 720, active lines
- V_FRONT, 5, vertical front porch
- SYNC_POL, 1, active level of hsync/vsync (1 = active-high)

Ports:
- sclk  in  1  pixel clock; one clock domain
- s_rst  in  1  reset, synchronous, active-high
- i_en  in  1  timing enable
- i_clr_err  in  1  clears sticky underflow flag
- o_pix_req  out  1  FIFO read strobe (1-cycle read latency FIFO)
- i_fifo_empty  in  1  FIFO empty
- i_pix_data  in  24  {r,g,b}; valid the cycle after o_pix_req
- o_frame_start  out  1  one-cycle pulse at h_cnt=0, v_cnt=0
- o_underflow  out  1  sticky underflow flag
- o_vga_vsync, o_vga_hsync, o_vga_de  out  1 each  to gamma stage
- o_vga_r, o_vga_g, o_vga_b  out  8 each  to gamma stage

Behaviour:
- Clock is sclk only. Reset s_rst is synchronous, active-high. All state is updated on the rising edge of sclk.
- Reset values:
  - h_cnt = 0, v_cnt = 0.
  - o_pix_req = 0, o_frame_start = 0, o_underflow = 0, o_vga_de = 0.
  - o_vga_hsync and o_vga_vsync = ~SYNC_POL.
  - o_vga_r/g/b = 0.
- Counters:
  - H_TOTAL = sum of the four H parameters; V_TOTAL = sum of the four V parameters.
  - h_cnt runs 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps, runs 0..V_TOTAL-1, and wraps to 0.
  - Counter widths are clog2 of the totals.
- Stage 0 (combinational from the counters):
  - hs_pre = (h_cnt < H_SYNC).
  - vs_pre = (v_cnt < V_SYNC).
  - de_pre = h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE) AND v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE).
- Fetch:
  - o_pix_req = de_pre & i_en, driven combinationally from the counter registers.
  - Exactly H_ACTIVE*V_ACTIVE requests are issued per frame, independent of i_fifo_empty.
- Pipeline:
  - Stage 1 registers hs/vs/de and an underflow bit u1 = o_pix_req & i_fifo_empty.
  - Stage 2 registers the outputs. Sync polarity applied: o_vga_hsync = hs ? SYNC_POL : ~SYNC_POL, same rule for vsync.
  - o_vga_r/g/b = i_pix_data captured in stage 2 when de1 = 1 and u1 = 0; otherwise 0.
  - Latency: o_pix_req at cycle t; i_pix_data valid at t+1; o_vga_* at t+2.
- Frame start: o_frame_start = 1 for exactly one cycle when h_cnt = 0 and v_cnt = 0 and i_en = 1. It is registered and aligned with stage 1.
- Underflow:
  - o_underflow is set the cycle after u1 = 1.
  - It holds until i_clr_err = 1 or reset. Set has priority over a simultaneous clear.
  - The pixel slot is output as black with de still asserted, so timing is preserved.
- Enable:
  - While i_en = 0, counters are held at 0, o_pix_req = 0, and the pipeline flushes to idle (de = 0, syncs inactive) within 2 cycles.
  - Rising i_en starts a new frame at h_cnt = 0, v_cnt = 0 with o_frame_start.
  - Dropping i_en mid-frame aborts the frame. The downstream controller must re-arm on the next o_frame_start.
- Reset mid-frame: all outputs go to reset values the next cycle and no further requests are issued.
- Sync and de edges are glitch-free because every output is driven from a register.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- With the macro defined:
  - Extra input i_pattern_sel (1 bit) is present.
  - When i_pattern_sel = 1, o_pix_req is forced to 0 and stage 2 outputs 8 vertical colour bars, each H_ACTIVE/8 pixels wide.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black. Components are 8'hFF or 8'h00.
  - The bar index comes from (h_cnt - H_SYNC - H_BACK), delayed to align with de.
  - Underflow is not evaluated while the pattern is selected.
- Without the macro: the port is absent and behaviour is as above.

Test Plan:
1. Small timing (H 2/2/8/2, V 1/1/4/1), FIFO never empty, incrementing data -> H_TOTAL = 14, V_TOTAL = 7. Per line: hsync high 2 clocks, de high 8 clocks starting 4 clocks after hsync rises. 32 o_pix_req per frame. o_vga_r/g/b equal to the i_pix_data sequence with 2-cycle latency from req. o_frame_start every 98 cycles.
2. Assert i_fifo_empty for one request in line 2 -> that pixel output = 0 with de = 1; o_underflow = 1 the next cycle. Pulse i_clr_err -> o_underflow returns to 0. Assert set and clear in the same cycle -> o_underflow stays 1.
3. Drop i_en mid-active line -> o_pix_req = 0 the same cycle, de = 0 within 2 cycles. Re-raise i_en -> o_frame_start with h_cnt = 0, v_cnt = 0.
4. Assert s_rst during active video -> next cycle all outputs at reset values: syncs = ~SYNC_POL, rgb = 0, o_underflow = 0.
5. SYNC_POL = 0 -> hsync/vsync idle high, pulse low for H_SYNC clocks / V_SYNC lines; de timing unchanged.
6. VGA_TEST_PATTERN_EN defined, i_pattern_sel = 1, H_ACTIVE = 16 -> no o_pix_req. Active pixels 0-1 = FFFFFF, 2-3 = FFFF00, ..., 14-15 = 000000.
